// File: rtl/hs_to_sync_if.sv
// Handshake and bus bundle between the 4-phase combine stage, this receiver
// and its clocked downstream consumer.
interface hs_to_sync_if #(
   parameter int WIDTH = 8
);
   logic             r_i;
   logic             a_i;
   logic [WIDTH-1:0] d_i;
   logic [WIDTH-1:0] d_o;
   logic             v_o;
   logic             rdy_i;

   // Environment side: drives the request, data and downstream ready
   modport master (
      output r_i,
      output d_i,
      output rdy_i,
      input  a_i,
      input  d_o,
      input  v_o
   );

   // Receiver side: answers the request and presents the captured data
   modport slave (
      input  r_i,
      input  d_i,
      input  rdy_i,
      output a_i,
      output d_o,
      output v_o
   );
endinterface

// File: rtl/hs_to_sync.sv
// Clocked receiver for a 4-phase bundled-data request from a join/combine
// stage. Synchronises the request, captures the bundled data into a one-entry
// output register, completes the return-to-zero handshake and presents the
// data as valid/ready. Also counts captures and flags withdrawn requests.
module hs_to_sync #(
   parameter int WIDTH = 8,
   parameter int SYNC  = 2,
   parameter int CNTW  = 16
) (
   input  logic            clk,
   input  logic            rst,
   hs_to_sync_if.slave     hs,
   output logic [CNTW-1:0] cnt_o,
   output logic            err_o
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ACK  = 1'b1;

   logic [SYNC-1:0]  sync_q;
   logic             rs;
   logic             rs_q;
   logic [0:0]       state;
   logic             ack_q;
   logic             valid_q;
   logic [WIDTH-1:0] data_q;
   logic [CNTW-1:0]  cnt_q;
   logic             err_q;
   logic             free;

   assign rs   = sync_q[SYNC-1];
   assign free = ~valid_q | hs.rdy_i;

   assign hs.a_i = ack_q;
   assign hs.v_o = valid_q;
   assign hs.d_o = data_q;
   assign cnt_o  = cnt_q;
   assign err_o  = err_q;

   // Bring the asynchronous request into the clock domain and keep one extra
   // delayed copy so a withdrawn request can be told apart from an idle line
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         rs_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC-2:0], hs.r_i};
         rs_q   <= rs;
      end
   end

   // Handshake FSM plus the output register; a capture in the same cycle as a
   // drain overrides the drain so v_o stays high with the new data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (valid_q && hs.rdy_i) begin
            valid_q <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (rs && free) begin
                  data_q  <= hs.d_i;
                  valid_q <= 1'b1;
                  cnt_q   <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                  ack_q   <= 1'b1;
                  state   <= ACK;
               end else if (!rs && rs_q) begin
                  err_q <= 1'b1;
               end
            end
            ACK: begin
               if (!rs) begin
                  ack_q <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               ack_q <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hs_to_sync.sv
// Self-checking bench for hs_to_sync: directed 4-phase tokens, a scoreboard
// of expected {data, count} pairs popped by a monitor on every transfer, and
// direct checks of handshake latency, back-pressure, error and reset.
module tb_hs_to_sync;

   localparam int WIDTH = 8;
   localparam int SYNC  = 2;
   localparam int CNTW  = 4;

   logic            clk;
   logic            rst;
   logic [CNTW-1:0] cnt_o;
   logic            err_o;

   logic [WIDTH+CNTW-1:0] expQ[$];
   logic [CNTW-1:0]       expCnt;
   int                    numCompared;
   int                    numFailed;

   hs_to_sync_if #(.WIDTH(WIDTH)) hs ();

   hs_to_sync #(
      .WIDTH(WIDTH),
      .SYNC (SYNC),
      .CNTW (CNTW)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .hs   (hs),
      .cnt_o(cnt_o),
      .err_o(err_o)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net in case some wait is never satisfied
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      numCompared++;
      if (actual !== expected) begin
         numFailed++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Each transfer (v_o & rdy_i at the coming edge) must match the oldest
   // expected token, both its data and its capture number
   always @(negedge clk) begin
      if (rst && hs.v_o && hs.rdy_i) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_output", {24'd0, hs.d_o}, 32'hFFFF_FFFF);
         end else begin
            logic [WIDTH+CNTW-1:0] exp;
            exp = expQ.pop_front();
            checkOutput("sb_data", {24'd0, hs.d_o}, {24'd0, exp[WIDTH+CNTW-1:CNTW]});
            checkOutput("sb_cnt", {28'd0, cnt_o}, {28'd0, exp[CNTW-1:0]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise the request with new data and record the expected capture
   task automatic applyStimulus(input logic [WIDTH-1:0] data);
      hs.d_i = data;
      hs.r_i = 1'b1;
      expCnt = expCnt + 1'b1;
      expQ.push_back({data, expCnt});
   endtask

   task automatic waitAck(input logic level, input string name);
      int n;
      n = 0;
      while (hs.a_i !== level && n < 40) begin
         tick();
         n++;
      end
      if (hs.a_i !== level) checkOutput(name, {31'd0, hs.a_i}, {31'd0, level});
   endtask

   task automatic sendToken(input logic [WIDTH-1:0] data);
      applyStimulus(data);
      waitAck(1'b1, "ack_rise_timeout");
      hs.r_i = 1'b0;
      waitAck(1'b0, "ack_fall_timeout");
   endtask

   task automatic doReset();
      rst = 1'b0;
      expQ.delete();
      expCnt = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      numCompared = 0;
      numFailed   = 0;
      expCnt      = '0;
      rst         = 1'b0;
      hs.r_i      = 1'b0;
      hs.d_i      = '0;
      hs.rdy_i    = 1'b1;

      // Test 1: reset values
      #1;
      checkOutput("rst_a", {31'd0, hs.a_i}, 32'd0);
      checkOutput("rst_v", {31'd0, hs.v_o}, 32'd0);
      checkOutput("rst_d", {24'd0, hs.d_o}, 32'd0);
      checkOutput("rst_cnt", {28'd0, cnt_o}, 32'd0);
      checkOutput("rst_err", {31'd0, err_o}, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Test 2: exact latency of capture and of ack release
      applyStimulus(8'hA5);
      tick();
      checkOutput("lat_a_e1", {31'd0, hs.a_i}, 32'd0);
      tick();
      checkOutput("lat_a_e2", {31'd0, hs.a_i}, 32'd0);
      checkOutput("lat_v_e2", {31'd0, hs.v_o}, 32'd0);
      tick();
      checkOutput("lat_a_e3", {31'd0, hs.a_i}, 32'd1);
      checkOutput("lat_v_e3", {31'd0, hs.v_o}, 32'd1);
      checkOutput("lat_d_e3", {24'd0, hs.d_o}, 32'hA5);
      hs.r_i = 1'b0;
      tick();
      tick();
      checkOutput("fall_a_e2", {31'd0, hs.a_i}, 32'd1);
      tick();
      checkOutput("fall_a_e3", {31'd0, hs.a_i}, 32'd0);
      checkOutput("cnt_after_a5", {28'd0, cnt_o}, 32'd1);
      tick();

      // Test 3: back-pressure holds the second token until ready rises
      doReset();
      hs.rdy_i = 1'b0;
      sendToken(8'h11);
      applyStimulus(8'h22);
      repeat (6) tick();
      checkOutput("bp_a_held", {31'd0, hs.a_i}, 32'd0);
      checkOutput("bp_d_held", {24'd0, hs.d_o}, 32'h11);
      checkOutput("bp_v_held", {31'd0, hs.v_o}, 32'd1);
      hs.rdy_i = 1'b1;
      tick();
      checkOutput("bp_d_new", {24'd0, hs.d_o}, 32'h22);
      checkOutput("bp_v_new", {31'd0, hs.v_o}, 32'd1);
      checkOutput("bp_a_new", {31'd0, hs.a_i}, 32'd1);
      checkOutput("bp_cnt", {28'd0, cnt_o}, 32'd2);
      hs.r_i = 1'b0;
      waitAck(1'b0, "bp_ack_fall_timeout");
      tick();

      // Test 4: request withdrawn before ack sets the sticky error
      hs.rdy_i = 1'b0;
      sendToken(8'h33);
      hs.d_i = 8'h44;
      hs.r_i = 1'b1;
      repeat (4) tick();
      hs.r_i = 1'b0;
      repeat (5) tick();
      checkOutput("err_set", {31'd0, err_o}, 32'd1);
      checkOutput("err_a", {31'd0, hs.a_i}, 32'd0);
      checkOutput("err_cnt", {28'd0, cnt_o}, 32'd3);
      checkOutput("err_d", {24'd0, hs.d_o}, 32'h33);
      hs.rdy_i = 1'b1;
      repeat (3) tick();
      checkOutput("err_sticky", {31'd0, err_o}, 32'd1);
      checkOutput("err_drained", {31'd0, hs.v_o}, 32'd0);

      // Test 5: seventeen back-to-back tokens, counter wraps 15 -> 0 -> 1
      doReset();
      for (int i = 0; i <= 16; i++) begin
         sendToken(i[WIDTH-1:0]);
      end
      tick();
      checkOutput("wrap_cnt", {28'd0, cnt_o}, 32'd1);
      checkOutput("wrap_err", {31'd0, err_o}, 32'd0);

      // Test 6: reset mid-handshake drops ack and valid at once
      hs.rdy_i = 1'b0;
      applyStimulus(8'h77);
      waitAck(1'b1, "rst_ack_timeout");
      #3;
      rst = 1'b0;
      expQ.delete();
      expCnt = '0;
      #1;
      checkOutput("mid_rst_a", {31'd0, hs.a_i}, 32'd0);
      checkOutput("mid_rst_v", {31'd0, hs.v_o}, 32'd0);
      checkOutput("mid_rst_cnt", {28'd0, cnt_o}, 32'd0);
      hs.r_i = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      hs.rdy_i = 1'b1;
      tick();
      sendToken(8'h88);
      tick();
      checkOutput("post_rst_cnt", {28'd0, cnt_o}, 32'd1);
      checkOutput("post_rst_d", {24'd0, hs.d_o}, 32'h88);
      repeat (3) tick();
      checkOutput("queue_empty", expQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numFailed);
      $finish;
   end

endmodule
